// File: rtl/vga_frame_gen.sv
// vga_frame_gen
// Frame-rate pulse generator on the VGA pixel clock. A one-cycle key strobe
// toggles the generator between IDLE and RUN. In RUN, a horizontal and a
// vertical counter track the raster (H_TOTAL x V_TOTAL clocks per frame).
// A registered one-cycle `frame` pulse marks every wrap of both counters
// back to (0, 0).
//
// Ports:
//   vga_clk     in   pixel clock; all logic on its rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   key_flag    in   debounced key strobe; each high edge toggles run/stop
//   frame       out  registered one-cycle pulse at each frame boundary
//   dbg_state_o out  current FSM state (0 = IDLE, 1 = RUN)
//   dbg_h_cnt_o out  horizontal raster counter
//   dbg_v_cnt_o out  vertical raster counter
//
// Strobe semantics: key_flag carries no handshake. Every rising edge of
// vga_clk that sees key_flag = 1 toggles the state, and that toggle wins
// over a frame wrap on the same edge (a stop on the wrap edge emits no pulse).
module vga_frame_gen #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int CNT_W   = 10
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic             key_flag,
  output logic             frame,
  output logic             dbg_state_o,
  output logic [CNT_W-1:0] dbg_h_cnt_o,
  output logic [CNT_W-1:0] dbg_v_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             frame_q, frame_d;

  logic h_last;
  logic v_last;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      frame_q <= frame_d;
    end
  end

  // Counters default to 0 so both the IDLE hold and every state toggle
  // (start or stop) leave the raster at (0, 0) after the edge.
  always_comb begin
    state_d = state_q;
    h_cnt_d = '0;
    v_cnt_d = '0;
    frame_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_flag) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (key_flag) begin
          state_d = IDLE;
        end else if (h_last) begin
          h_cnt_d = '0;
          v_cnt_d = v_last ? '0 : (v_cnt_q + CNT_ONE);
          frame_d = v_last;
        end else begin
          h_cnt_d = h_cnt_q + CNT_ONE;
          v_cnt_d = v_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign frame       = frame_q;
  assign dbg_state_o = state_q;
  assign dbg_h_cnt_o = h_cnt_q;
  assign dbg_v_cnt_o = v_cnt_q;

endmodule

// File: tb/tb_vga_frame_gen.sv
module tb_vga_frame_gen;

  localparam int H = 8;
  localparam int V = 4;
  localparam int W = 4;
  localparam int P = H * V;

  // ---------------- clock / reset ----------------
  logic         vga_clk;
  logic         sys_rst_n;
  logic         key_flag;
  logic         frame;
  logic         dbg_state;
  logic [W-1:0] dbg_h_cnt;
  logic [W-1:0] dbg_v_cnt;

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  vga_frame_gen #(
    .H_TOTAL(H),
    .V_TOTAL(V),
    .CNT_W  (W)
  ) dut (
    .vga_clk    (vga_clk),
    .sys_rst_n  (sys_rst_n),
    .key_flag   (key_flag),
    .frame      (frame),
    .dbg_state_o(dbg_state),
    .dbg_h_cnt_o(dbg_h_cnt),
    .dbg_v_cnt_o(dbg_v_cnt)
  );

  // ---------------- reference model ----------------
  // Running flag plus the number of edges elapsed since the start strobe.
  // Everything expected follows from that count with plain arithmetic.
  int   checks   = 0;
  int   failures = 0;
  bit   m_run    = 1'b0;
  int   m_k      = 0;
  int   pulses   = 0;
  logic exp_frame;
  int   exp_pulse_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("frame", {31'd0, frame}, {31'd0, exp_frame});
    check("state", {31'd0, dbg_state}, {31'd0, m_run});
    check("h_cnt", {28'd0, dbg_h_cnt}, m_run ? (m_k % H) : 0);
    check("v_cnt", {28'd0, dbg_v_cnt}, m_run ? ((m_k / H) % V) : 0);
  endtask

  // ---------------- driver ----------------
  // Drives key_flag for one edge, advances the model, samples 1 time unit
  // after the edge.
  task automatic tick(input logic k);
    key_flag = k;
    @(posedge vga_clk);
    if (sys_rst_n) begin
      if (k) begin
        m_run = !m_run;
        m_k   = 0;
      end else if (m_run) begin
        m_k++;
      end
    end
    exp_frame = sys_rst_n && m_run && !k && (m_k != 0) && ((m_k % P) == 0);
    #1;
    if (frame === 1'b1) pulses++;
    check_all();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    sys_rst_n = 1'b0;
    key_flag  = 1'b0;
    exp_frame = 1'b0;
    #5;
    check_all();

    // Key strobes while reset is held are ignored.
    for (int i = 0; i < 6; i++) tick(logic'(i[0]));
    #10 sys_rst_n = 1'b1;

    // Start right after reset: pulses after E0+32 and E0+64, one cycle each.
    pulses = 0;
    tick(1'b1);
    exp_pulse_q.push_back(P);
    exp_pulse_q.push_back(2 * P);
    for (int e = 1; e <= 2 * P + 5; e++) begin
      tick(1'b0);
      if (frame === 1'b1) begin
        int exp_e;
        exp_e = (exp_pulse_q.size() != 0) ? exp_pulse_q.pop_front() : -1;
        check("pulse_edge", e, exp_e);
      end
    end
    check("pulse_count", pulses, 2);
    check("pulse_q_empty", exp_pulse_q.size(), 0);

    // Stop mid-frame at E0+10, restart at E0+50, first pulse after E0+82.
    tick(1'b1);                       // stop
    tick(1'b1);                       // E0
    idle_ticks(9);
    pulses = 0;
    tick(1'b1);                       // E0+10 stop
    idle_ticks(39);
    check("no_pulse_stopped", pulses, 0);
    tick(1'b1);                       // E0+50 restart
    idle_ticks(31);
    check("before_restart_pulse", pulses, 0);
    tick(1'b0);                       // E0+82
    check("restart_pulse", {31'd0, frame}, 32'd1);

    // Stop exactly on the wrap edge: no pulse, IDLE afterward.
    tick(1'b1);                       // stop
    tick(1'b1);                       // E0
    idle_ticks(P - 1);
    pulses = 0;
    tick(1'b1);                       // E0+32
    idle_ticks(3);
    check("wrap_stop_no_pulse", pulses, 0);
    check("wrap_stop_idle", {31'd0, dbg_state}, 32'd0);

    // Asynchronous reset while frame is high: drops with no clock edge.
    tick(1'b1);
    idle_ticks(P);
    check("pre_reset_frame", {31'd0, frame}, 32'd1);
    #5 sys_rst_n = 1'b0;
    #1;
    m_run     = 1'b0;
    m_k       = 0;
    exp_frame = 1'b0;
    check_all();
    #4 sys_rst_n = 1'b1;

    // Idle immunity: no strobes, frame never asserts.
    pulses = 0;
    idle_ticks(2000);
    check("idle_no_pulse", pulses, 0);

    // Random sparse strobes against the model.
    for (int i = 0; i < 3000; i++) tick(logic'($urandom_range(0, 79) == 0));

    // Random mid-cycle reset then a clean restart.
    tick(1'b1);
    idle_ticks($urandom_range(1, 2 * P));
    #7 sys_rst_n = 1'b0;
    #1;
    m_run     = 1'b0;
    m_k       = 0;
    exp_frame = 1'b0;
    check_all();
    #3 sys_rst_n = 1'b1;
    tick(1'b1);
    idle_ticks(3 * P);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
